shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and sequencer granting NREQ requesters exclusive write access to one shared WIDTH-bit register built from D flip-flop cells.
- Each winning requester applies one operation (load, clear, preset or hold), then receives a one-cycle grant acknowledge.
- Sits between multiple control agents and a shared state/config register. Also exports the register value (q) and its complement (nq).

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register.
- IDXW, $clog2(NREQ), width of the owner index.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- req  input  NREQ  per-requester request; held high until its gnt is seen.
- op  input  2*NREQ  per-requester operation, requester i at bits [2i+1:2i]: 00 load, 01 clear, 10 preset, 11 hold.
- din  input  WIDTH*NREQ  per-requester load data, requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
- gnt  output  NREQ  one-hot acknowledge, high for exactly one cycle per served request.
- q  output  WIDTH  shared register value.
- nq  output  WIDTH  always ~q (combinational).
- owner  output  IDXW  index of the requester being served; valid while busy.
- busy  output  1  high when FSM is not IDLE.

Behaviour:
- Reset (rst low, async, any state):
  - q=0, nq=all ones, gnt=0, busy=0, owner=0, state=IDLE.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Any in-flight operation is aborted with no register update and no gnt.
- FSM states: IDLE, EXEC, ACK.
- IDLE:
  - If req != 0, pick the winner: first set bit scanning from last+1 upward, wrapping modulo NREQ.
  - Latch the winner into owner; latch its op and din into holding registers; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (one cycle), operation committed on the edge leaving EXEC:
  - load: q <= latched din.
  - clear: q <= 0.
  - preset: q <= all ones.
  - hold: q unchanged.
  - Set last <= owner; go to ACK.
- ACK (one cycle):
  - gnt[owner]=1 (registered); all other gnt bits 0.
  - Go to IDLE.
- Latency: req high in IDLE cycle n -> q updated after edge n+1 -> gnt high during cycle n+2 -> back in IDLE cycle n+3. Throughput is one operation per 3 cycles.
- Requester handshake: on seeing gnt, the requester drops req on that same edge. A req still high in the following IDLE cycle is treated as a new request.
- Op and din are sampled only at the IDLE->EXEC edge. Later changes, including dropping req during EXEC/ACK, do not cancel or alter the committed operation, and gnt is still issued.
- Requests arriving while busy wait. No request is lost while its req stays high.
- Fairness: a requester held continuously waits at most NREQ-1 other grants.
- Simultaneous requests are resolved solely by the round-robin pointer; no fixed priority beyond reset.
- busy=1 in EXEC and ACK. owner holds its value in IDLE (don't-care to consumers).
- nq tracks q in all states, including during reset.

Test Plan:
- Reset values: hold rst=0 mid-simulation, toggle clk and drive req=4'b1111 -> q=8'h00, nq=8'hFF, gnt=0, busy=0, owner=0; release rst -> first grant goes to requester 0.
- Single load: req=4'b0100, op2=00, din2=8'hA5 in IDLE at cycle n -> busy=1 at n+1, q=8'hA5 and nq=8'h5A after edge n+1, gnt=4'b0100 for exactly cycle n+2, idle at n+3.
- Round-robin ordering: all four requesters assert together and hold until granted, with load data 8'h10/11/12/13 -> gnt order 0,1,2,3, q sequence 10,11,12,13. Re-request 1 and 3 together -> 3 is not starved: order is 1 then 3 (pointer after 3 wraps to 0).
- Clear/preset/hold: q=8'h3C, then preset -> 8'hFF, hold -> 8'hFF, clear -> 8'h00. Each op produces one gnt pulse.
- Drop during EXEC: requester 1 loads 8'h77 and drops req in EXEC -> q=8'h77 and gnt[1] still pulses once.
- Reset mid-operation: assert rst low during EXEC of a load 8'hEE with q=8'h42 -> q=8'h00 immediately, no gnt pulse, state IDLE. After release, a still-held req is served normally.

Source files
------------

// File: rtl/shared_reg_arbiter_if.sv
// Bundle of requester-side and register-side signals for shared_reg_arbiter.
// The master modport is the requester cluster; the slave modport is the arbiter.
interface shared_reg_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      nq;
    logic [IDXW-1:0]       owner;
    logic                  busy;

    modport master (output req, op, din, input gnt, q, nq, owner, busy);
    modport slave  (input req, op, din, output gnt, q, nq, owner, busy);
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin sequencer giving NREQ requesters exclusive write access to one
// shared register: pick in IDLE, commit the latched operation in EXEC, acknowledge in ACK.
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    shared_reg_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  owner_q, owner_d;
    logic [IDXW-1:0]  last_q, last_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] din_arr_s [NREQ];
    logic [1:0]       op_arr_s  [NREQ];
    logic             pick_found_s;
    logic [IDXW-1:0]  pick_idx_s;
    logic [IDXW-1:0]  cand_s;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign din_arr_s[g] = bus.din[WIDTH*g +: WIDTH];
        assign op_arr_s[g]  = bus.op[2*g +: 2];
    end

    // Round-robin winner: first active request strictly after the last served index.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {IDXW{1'b0}};
        cand_s       = {IDXW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDXW'((int'(last_q) + k) % NREQ);
            if (!pick_found_s && bus.req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Sequencer next-state: latch on pick, commit on leaving EXEC, pulse gnt in ACK.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_d    = op_q;
        din_d   = din_q;
        q_d     = q_q;
        gnt_d   = {NREQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_EXEC;
                    owner_d = pick_idx_s;
                    op_d    = op_arr_s[pick_idx_s];
                    din_d   = din_arr_s[pick_idx_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LOAD:   q_d = din_q;
                    OP_CLEAR:  q_d = {WIDTH{1'b0}};
                    OP_PRESET: q_d = {WIDTH{1'b1}};
                    default:   q_d = q_q;
                endcase
                last_d         = owner_q;
                gnt_d[owner_q] = 1'b1;
                state_d        = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; reset abandons any in-flight operation without committing it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= {IDXW{1'b0}};
            last_q  <= IDXW'(NREQ - 1);
            op_q    <= 2'b00;
            din_q   <= {WIDTH{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            gnt_q   <= {NREQ{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            din_q   <= din_d;
            q_q     <= q_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.q     = q_q;
    assign bus.nq    = ~q_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized and directed bench for shared_reg_arbiter against a transaction-timed
// reference model (winner chosen by round-robin rule, outputs derived from start time).
module tb_shared_reg_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    shared_reg_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    shared_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int         cyc;
    bit         m_active;
    int         m_start;
    int         m_w;
    int         m_owner;
    int         m_last;
    logic [7:0] m_q;
    logic [7:0] m_newq;
    logic [3:0] exp_gnt;
    logic       exp_busy;
    logic [1:0] exp_owner;
    logic [7:0] exp_q;

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic int gnt_index(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_q       = 8'h00;
        m_last    = 3;
        m_owner   = 0;
        exp_gnt   = 4'b0000;
        exp_busy  = 1'b0;
        exp_owner = 2'd0;
        exp_q     = 8'h00;
    endtask

    // One clock: advance model, cross edge, compute expectations, requesters drop on gnt.
    task automatic step();
        int         w;
        logic [1:0] o;
        logic [7:0] d;
        if (!m_active) begin
            if (bus.req != 4'b0000) begin
                w        = rr_pick(bus.req, m_last);
                o        = bus.op[2*w +: 2];
                d        = bus.din[8*w +: 8];
                m_active = 1'b1;
                m_start  = cyc;
                m_w      = w;
                m_owner  = w;
                m_newq   = (o == 2'b00) ? d : (o == 2'b01) ? 8'h00 : (o == 2'b10) ? 8'hFF : m_q;
            end
        end else if (cyc == m_start + 1) begin
            m_q    = m_newq;
            m_last = m_w;
        end else begin
            m_active = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc       = cyc + 1;
        exp_busy  = m_active;
        exp_gnt   = (m_active && cyc == m_start + 2) ? (4'b0001 << m_w) : 4'b0000;
        exp_owner = 2'(m_owner);
        exp_q     = m_q;
        for (int i = 0; i < 4; i++) if (bus.gnt[i]) bus.req[i] = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        bus.req = 4'b1111;
        bus.op  = 8'h00;
        bus.din = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        rst     = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.q !== 8'h00 || bus.nq !== 8'hFF || bus.gnt !== 4'b0000 ||
                bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
                bad++;
                $display("FAIL reset_vals k=%0d got q=%h nq=%h gnt=%b busy=%b owner=%0d need 00 FF 0000 0 0",
                         k, bus.q, bus.nq, bus.gnt, bus.busy, bus.owner);
            end
            @(posedge clk);
            #1;
        end
        model_reset();
        rst   = 1'b1;
        first = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.req == 4'b0000 && !m_active) break;
            step();
            total++;
            if ({bus.gnt, bus.q, bus.nq, bus.busy, bus.owner} !== {exp_gnt, exp_q, ~exp_q, exp_busy, exp_owner}) begin
                bad++;
                $display("FAIL reset_drain cyc=%0d got gnt=%b q=%h nq=%h busy=%b own=%0d need gnt=%b q=%h busy=%b own=%0d",
                         cyc, bus.gnt, bus.q, bus.nq, bus.busy, bus.owner, exp_gnt, exp_q, exp_busy, exp_owner);
            end
            if (first < 0 && bus.gnt != 4'b0000) first = gnt_index(bus.gnt);
        end
        total++;
        if (first !== 0) begin
            bad++;
            $display("FAIL reset_first_grant got %0d need 0", first);
        end
    endtask

    task automatic test_round_robin();
        int         order[$];
        logic [7:0] qs[$];
        bus.req = 4'b1111;
        bus.op  = 8'h00;
        bus.din = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 40; k++) begin
            if (bus.req == 4'b0000 && !m_active) break;
            step();
            total++;
            if ({bus.gnt, bus.q, bus.nq, bus.busy, bus.owner} !== {exp_gnt, exp_q, ~exp_q, exp_busy, exp_owner}) begin
                bad++;
                $display("FAIL rr_cycle cyc=%0d got gnt=%b q=%h busy=%b own=%0d need gnt=%b q=%h busy=%b own=%0d",
                         cyc, bus.gnt, bus.q, bus.busy, bus.owner, exp_gnt, exp_q, exp_busy, exp_owner);
            end
            if (bus.gnt != 4'b0000) begin
                order.push_back(gnt_index(bus.gnt));
                qs.push_back(bus.q);
            end
        end
        total++;
        if (order.size() != 4) begin
            bad++;
            $display("FAIL rr_count got %0d grants need 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (order[i] != i || qs[i] !== 8'(8'h10 + i)) begin
                    bad++;
                    $display("FAIL rr_order slot=%0d got idx=%0d q=%h need idx=%0d q=%h", i, order[i], qs[i], i, 8'(8'h10 + i));
                end
            end
        end
        order.delete();
        bus.req = 4'b1010;
        for (int k = 0; k < 20; k++) begin
            if (bus.req == 4'b0000 && !m_active) break;
            step();
            if (bus.gnt != 4'b0000) order.push_back(gnt_index(bus.gnt));
        end
        total++;
        if (order.size() != 2 || order[0] != 1 || order[1] != 3) begin
            bad++;
            $display("FAIL rr_rerequest got n=%0d first=%0d need order 1,3", order.size(), (order.size() > 0) ? order[0] : -1);
        end
    endtask

    task automatic test_single_load();
        bus.op       = 8'h00;
        bus.din      = 32'h0;
        bus.din[23:16] = 8'hA5;
        bus.req      = 4'b0100;
        step();
        total++;
        if (bus.busy !== 1'b1 || bus.gnt !== 4'b0000 || bus.owner !== 2'd2) begin
            bad++;
            $display("FAIL load_n1 got busy=%b gnt=%b own=%0d need 1 0000 2", bus.busy, bus.gnt, bus.owner);
        end
        step();
        total++;
        if (bus.q !== 8'hA5 || bus.nq !== 8'h5A || bus.gnt !== 4'b0100) begin
            bad++;
            $display("FAIL load_n2 got q=%h nq=%h gnt=%b need A5 5A 0100", bus.q, bus.nq, bus.gnt);
        end
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.q !== exp_q) begin
            bad++;
            $display("FAIL load_n3 got busy=%b gnt=%b q=%h need 0 0000 %h", bus.busy, bus.gnt, bus.q, exp_q);
        end
    endtask

    task automatic test_ops();
        logic [1:0] t_op  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        logic [7:0] t_din [4] = '{8'h3C, 8'h00, 8'h5A, 8'h99};
        logic [7:0] t_exp [4] = '{8'h3C, 8'hFF, 8'hFF, 8'h00};
        int pulses;
        for (int i = 0; i < 4; i++) begin
            bus.op[2*i +: 2]  = t_op[i];
            bus.din[8*i +: 8] = t_din[i];
            bus.req           = 4'b0001 << i;
            pulses            = 0;
            for (int k = 0; k < 6; k++) begin
                step();
                total++;
                if ({bus.gnt, bus.q, bus.nq, bus.busy} !== {exp_gnt, exp_q, ~exp_q, exp_busy}) begin
                    bad++;
                    $display("FAIL ops_cycle i=%0d cyc=%0d got gnt=%b q=%h busy=%b need gnt=%b q=%h busy=%b",
                             i, cyc, bus.gnt, bus.q, bus.busy, exp_gnt, exp_q, exp_busy);
                end
                if (bus.gnt == (4'b0001 << i)) pulses++;
            end
            total++;
            if (pulses != 1 || bus.q !== t_exp[i]) begin
                bad++;
                $display("FAIL ops_result i=%0d got pulses=%0d q=%h need 1 %h", i, pulses, bus.q, t_exp[i]);
            end
        end
    endtask

    task automatic test_drop_exec();
        int pulses;
        bus.op[3:2]   = 2'b00;
        bus.din[15:8] = 8'h77;
        bus.req       = 4'b0010;
        step();
        bus.req = 4'b0000;
        bus.din[15:8] = 8'h00;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus.gnt == 4'b0010) pulses++;
            total++;
            if (bus.gnt !== exp_gnt || bus.q !== exp_q) begin
                bad++;
                $display("FAIL drop_cycle cyc=%0d got gnt=%b q=%h need gnt=%b q=%h", cyc, bus.gnt, bus.q, exp_gnt, exp_q);
            end
        end
        total++;
        if (pulses != 1 || bus.q !== 8'h77) begin
            bad++;
            $display("FAIL drop_exec got pulses=%0d q=%h need 1 77", pulses, bus.q);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses;
        bus.op[1:0]  = 2'b00;
        bus.din[7:0] = 8'h42;
        bus.req      = 4'b0001;
        repeat (4) step();
        total++;
        if (bus.q !== 8'h42) begin
            bad++;
            $display("FAIL midrst_setup got q=%h need 42", bus.q);
        end
        bus.din[7:0] = 8'hEE;
        bus.req      = 4'b0001;
        step();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.q !== 8'h00 || bus.nq !== 8'hFF || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_async got q=%h nq=%h busy=%b gnt=%b need 00 FF 0 0000", bus.q, bus.nq, bus.busy, bus.gnt);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
            bad++;
            $display("FAIL midrst_hold got gnt=%b busy=%b q=%h need 0000 0 00", bus.gnt, bus.busy, bus.q);
        end
        model_reset();
        rst    = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.gnt == 4'b0001) pulses++;
            total++;
            if ({bus.gnt, bus.q, bus.busy} !== {exp_gnt, exp_q, exp_busy}) begin
                bad++;
                $display("FAIL midrst_cycle cyc=%0d got gnt=%b q=%h busy=%b need gnt=%b q=%h busy=%b",
                         cyc, bus.gnt, bus.q, bus.busy, exp_gnt, exp_q, exp_busy);
            end
        end
        total++;
        if (pulses != 1 || bus.q !== 8'hEE) begin
            bad++;
            $display("FAIL midrst_after got pulses=%0d q=%h need 1 EE", pulses, bus.q);
        end
    endtask

    task automatic test_random();
        int waits [4] = '{0, 0, 0, 0};
        int j;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.req[i] && $urandom_range(0, 3) == 0) bus.req[i] = 1'b1;
            end
            bus.op  = 8'($urandom);
            bus.din = $urandom;
            step();
            total++;
            if ({bus.gnt, bus.q, bus.nq, bus.busy, bus.owner} !== {exp_gnt, exp_q, ~exp_q, exp_busy, exp_owner}) begin
                bad++;
                $display("FAIL rand_cycle cyc=%0d got gnt=%b q=%h nq=%h busy=%b own=%0d need gnt=%b q=%h busy=%b own=%0d",
                         cyc, bus.gnt, bus.q, bus.nq, bus.busy, bus.owner, exp_gnt, exp_q, exp_busy, exp_owner);
            end
            if (bus.gnt != 4'b0000) begin
                j = gnt_index(bus.gnt);
                waits[j] = 0;
                for (int i = 0; i < 4; i++) begin
                    if (i != j && bus.req[i]) begin
                        waits[i]++;
                        total++;
                        if (waits[i] > 3) begin
                            bad++;
                            $display("FAIL rand_fairness req=%0d got waits=%0d need <=3", i, waits[i]);
                        end
                    end
                end
            end
        end
        for (int k = 0; k < 40; k++) begin
            if (bus.req == 4'b0000 && !m_active) break;
            step();
        end
        total++;
        if (bus.req !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rand_drain got req=%b busy=%b need 0000 0", bus.req, bus.busy);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        rst     = 1'b0;
        bus.req = 4'b0000;
        bus.op  = 8'h00;
        bus.din = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) step();
        test_reset();
        test_round_robin();
        test_single_load();
        test_ops();
        test_drop_exec();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
